// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement operation when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_dvd;    // dividend shifts out of the top, quotient fills the bottom
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_prem;
    logic [CW-1:0]    r_cnt;
    logic             r_zero;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot, r_rem;

    logic [WIDTH-1:0] w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_dvd_in, w_dvs_in, w_q_out, w_r_out;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic r_neg_q, r_neg_r;

    // A zero divisor keeps the raw dividend so it can be returned as the remainder.
    always_comb begin
        w_dvd_in = dividend;
        if (divisor != '0 && dividend[WIDTH-1])
            w_dvd_in = -dividend;
        w_dvs_in = divisor[WIDTH-1] ? -divisor : divisor;
        w_q_out  = r_neg_q ? -r_dvd : r_dvd;
        w_r_out  = r_neg_r ? -r_prem : r_prem;
    end
`else
    always_comb begin
        w_dvd_in = dividend;
        w_dvs_in = divisor;
        w_q_out  = r_dvd;
        w_r_out  = r_prem;
    end
`endif

    // The partial remainder is always below 2**(WIDTH-1) before the final shift,
    // so dropping its MSB is safe; the subtract is one bit wider to expose the borrow.
    assign w_rem_shift = {r_prem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign w_diff      = {1'b0, w_rem_shift} - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output is given a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_dvd   <= w_dvd_in;
                    r_dvs   <= w_dvs_in;
                    r_prem  <= '0;
                    r_cnt   <= '0;
                    r_zero  <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
                    r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_r <= dividend[WIDTH-1];
`endif
                end
                S_RUN: begin
                    r_dvd  <= {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_prem <= w_diff[WIDTH] ? w_rem_shift : w_diff[WIDTH-1:0];
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_zero) begin
                        r_quot <= '1;
                        r_rem  <= r_dvd;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= w_q_out;
                        r_rem  <= w_r_out;
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an 8-bit instance for random/boundary work
// and a 64-bit instance for reset-abort and full-width latency.
`timescale 1ns/1ps
module tb_seq_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t q8[$];
    exp_t q64[$];

    logic        d8_start = 1'b0;
    logic [7:0]  d8_dvd = '0, d8_dvs = '0;
    logic        d8_busy, d8_done, d8_dbz;
    logic [7:0]  d8_quot, d8_rem;

    logic        d64_start = 1'b0;
    logic [63:0] d64_dvd = '0, d64_dvs = '0;
    logic        d64_busy, d64_done, d64_dbz;
    logic [63:0] d64_quot, d64_rem;

    seq_divider #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(d8_start),
        .dividend(d8_dvd), .divisor(d8_dvs),
        .busy(d8_busy), .done(d8_done),
        .quotient(d8_quot), .remainder(d8_rem), .div_by_zero(d8_dbz)
    );

    seq_divider #(.WIDTH(64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .start(d64_start),
        .dividend(d64_dvd), .divisor(d64_dvs),
        .busy(d64_busy), .done(d64_done),
        .quotient(d64_quot), .remainder(d64_rem), .div_by_zero(d64_dbz)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the 8-bit operands.
    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [7:0] qq, rr;
        e.dbz = 1'b0;
        e.due = 0;
        if (b == 8'd0) begin
            qq    = 8'hFF;
            rr    = a;
            e.dbz = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            qq = 8'(sa / sb);
            rr = 8'(sa % sb);
`else
            qq = a / b;
            rr = a % b;
`endif
        end
        e.q = {56'd0, qq};
        e.r = {56'd0, rr};
        return e;
    endfunction

    always @(negedge clk) begin
        if (d8_done) begin
            check("d8_done_expected", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                exp_t e;
                e = q8.pop_front();
                check("d8_latency", 64'(cyc), 64'(e.due));
                check("d8_quotient", {56'd0, d8_quot}, e.q);
                check("d8_remainder", {56'd0, d8_rem}, e.r);
                check("d8_div_by_zero", 64'(d8_dbz), 64'(e.dbz));
            end
        end
    end

    always @(negedge clk) begin
        if (d64_done) begin
            check("d64_done_expected", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) begin
                exp_t e;
                e = q64.pop_front();
                check("d64_latency", 64'(cyc), 64'(e.due));
                check("d64_quotient", d64_quot, e.q);
                check("d64_remainder", d64_rem, e.r);
                check("d64_div_by_zero", 64'(d64_dbz), 64'(e.dbz));
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        exp_t e;
        while (d8_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (d8_busy) check("d8_idle_timeout", 64'(d8_busy), 64'd0);
        d8_start = 1'b1;
        d8_dvd   = a;
        d8_dvs   = b;
        e = model8(a, b);
        e.due = cyc + 1 + ((b == 8'd0) ? 1 : 9);
        q8.push_back(e);
        @(negedge clk);
        d8_start = 1'b0;
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input bit expect_result);
        int n = 0;
        exp_t e;
        while (d64_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (d64_busy) check("d64_idle_timeout", 64'(d64_busy), 64'd0);
        d64_start = 1'b1;
        d64_dvd   = a;
        d64_dvs   = b;
        if (expect_result) begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
            e.due = cyc + 1 + 65;
            q64.push_back(e);
        end
        @(negedge clk);
        d64_start = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        check("rst_d8_busy", 64'(d8_busy), 64'd0);
        check("rst_d8_done", 64'(d8_done), 64'd0);
        check("rst_d8_quot", {56'd0, d8_quot}, 64'd0);
        check("rst_d8_rem", {56'd0, d8_rem}, 64'd0);
        check("rst_d8_dbz", 64'(d8_dbz), 64'd0);
        check("rst_d64_busy", 64'(d64_busy), 64'd0);
        check("rst_d64_quot", d64_quot, 64'd0);
        check("rst_d64_rem", d64_rem, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-width basic operation and busy window.
        issue64(64'd1000, 64'd7, 1'b1);
        n = 0;
        while (!d64_done && n < 200) begin
            if (d64_busy) n++;
            @(negedge clk);
        end
        check("d64_busy_cycles", 64'(n), 64'd65);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        issue64(64'd100, 64'd7, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_quot", d64_quot, 64'd0);
        check("midrst_rem", d64_rem, 64'd0);
        check("midrst_busy", 64'(d64_busy), 64'd0);
        check("midrst_done", 64'(d64_done), 64'd0);
        check("midrst_dbz", 64'(d64_dbz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("midrst_idle", 64'(d64_busy), 64'd0);
        issue64(64'd100, 64'd7, 1'b1);

        // Boundaries on the 8-bit instance, back to back.
        issue8(8'd255, 8'd128);
        issue8(8'd100, 8'd200);
        issue8(8'd37, 8'd0);
        issue8(8'd9, 8'd3);
        issue8(8'd0, 8'd255);
        issue8(8'd255, 8'd1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        issue8(8'hF9, 8'd2);
        issue8(8'd7, 8'hFE);
        issue8(8'h80, 8'hFF);
        issue8(8'h80, 8'd0);
`endif

        // start re-pulsed mid-run and held through DONE.
        issue8(8'd200, 8'd9);
        repeat (3) @(negedge clk);
        d8_start = 1'b1;
        d8_dvd   = 8'd50;
        d8_dvs   = 8'd5;
        n = 0;
        while (!d8_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        begin
            exp_t e;
            e = model8(8'd50, 8'd5);
            e.due = cyc + 1 + 9;
            q8.push_back(e);
        end
        @(negedge clk);
        d8_start = 1'b0;

        // Random operands, biased toward zero and MSB-set divisors.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            int sel;
            a   = 8'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      b = 8'd0;
            else if (sel < 3)  b = 8'h80 | 8'($urandom);
            else               b = 8'($urandom);
            issue8(a, b);
        end

        n = 0;
        while ((q8.size() != 0 || q64.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(q8.size() + q64.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
